// File: rtl/switch_event_arbiter_pkg.sv
// sw_evt_pkg: shared types and helpers for switch_event_arbiter.
`default_nettype none

package sw_evt_pkg;

  localparam int NUM_BITS_DEF = 18;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_t;

  // Wrap-around increment of a lane index within [0, n-1].
  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/switch_event_arbiter_rr_select.sv
// rr_select: finds the first set request bit searching upward from start, wrapping N-1 -> 0.
`default_nettype none

module rr_select #(
  parameter int N = 18,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] idx
);

  logic [W:0] pos;

  // Scan offsets from the far end so the nearest hit to start is written last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = {1'b0, start} + (W+1)'(k);
      if (pos >= (W+1)'(N)) begin
        pos = pos - (W+1)'(N);
      end
      if (req[pos[W-1:0]]) begin
        found = 1'b1;
        idx   = pos[W-1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/switch_event_arbiter.sv
// switch_event_arbiter: queues switch edge pulses and serves them one at a time over valid/ready.
// Define SW_ARB_FIXED_PRIO_EN for lowest-index-wins priority instead of round-robin.
`default_nettype none

module switch_event_arbiter
  import sw_evt_pkg::*;
#(
  parameter int NUM_BITS = NUM_BITS_DEF,
  parameter int IDX_W    = $clog2(NUM_BITS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_BITS-1:0] edge_pulse,
  output logic                evt_valid,
  output logic [IDX_W-1:0]    evt_idx,
  input  logic                evt_ready,
  output logic [NUM_BITS-1:0] pending,
  output logic [NUM_BITS-1:0] overflow,
  input  logic                ovf_clr,
  output logic                busy
);

  arb_state_t          state;
  logic [IDX_W-1:0]    start_ptr;
  logic [IDX_W-1:0]    sel_idx;
  logic                sel_found;
  logic                do_grant;
  logic [NUM_BITS-1:0] grant_mask;
  logic [NUM_BITS-1:0] ovf_set;

`ifdef SW_ARB_FIXED_PRIO_EN
  assign start_ptr = '0;
`else
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] ptr_after;

  assign ptr_after = IDX_W'(next_idx(32'(evt_idx), NUM_BITS));
  // On accept the search restarts just past the lane that was served.
  assign start_ptr = (state == OFFER) ? ptr_after : rr_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (state == OFFER && evt_ready) begin
      rr_ptr <= ptr_after;
    end
  end
`endif

  rr_select #(
    .N (NUM_BITS),
    .W (IDX_W)
  ) u_rr_select (
    .req   (pending),
    .start (start_ptr),
    .found (sel_found),
    .idx   (sel_idx)
  );

  assign do_grant   = sel_found && (state == IDLE || evt_ready);
  assign grant_mask = do_grant ? (NUM_BITS'(1) << sel_idx) : '0;
  assign ovf_set    = edge_pulse & pending & ~grant_mask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      evt_idx  <= '0;
      pending  <= '0;
      overflow <= '0;
    end else begin
      pending  <= (pending & ~grant_mask) | edge_pulse;
      overflow <= (ovf_clr ? '0 : overflow) | ovf_set;
      case (state)
        IDLE: begin
          if (sel_found) begin
            state   <= OFFER;
            evt_idx <= sel_idx;
          end
        end
        OFFER: begin
          if (evt_ready) begin
            if (sel_found) begin
              evt_idx <= sel_idx;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign evt_valid = (state == OFFER);
  assign busy      = evt_valid | (|pending);

endmodule

`default_nettype wire

// File: tb/tb_switch_event_arbiter.sv
// Directed self-checking bench for switch_event_arbiter.
`default_nettype none

module tb_switch_event_arbiter;

  localparam int NB = 18;
  localparam int IW = $clog2(NB);

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] edge_pulse;
  logic          evt_valid;
  logic [IW-1:0] evt_idx;
  logic          evt_ready;
  logic [NB-1:0] pending;
  logic [NB-1:0] overflow;
  logic          ovf_clr;
  logic          busy;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  switch_event_arbiter #(.NUM_BITS(NB)) dut (
    .clk        (clk),
    .rst        (rst),
    .edge_pulse (edge_pulse),
    .evt_valid  (evt_valid),
    .evt_idx    (evt_idx),
    .evt_ready  (evt_ready),
    .pending    (pending),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr),
    .busy       (busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    rst = 1'b1; edge_pulse = '0; evt_ready = 1'b0; ovf_clr = 1'b0;
    tick; tick;
    check("rst_valid", 32'(evt_valid), 0);
    check("rst_idx", 32'(evt_idx), 0);
    check("rst_pending", 32'(pending), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    tick;

    // Lanes 5 and 12 together from rr_ptr=0
    evt_ready = 1'b1;
    edge_pulse = 18'h01020;
    tick;
    edge_pulse = '0;
    check("sim_pending", 32'(pending), 32'h01020);
    check("sim_valid0", 32'(evt_valid), 0);
    check("sim_busy", 32'(busy), 1);
    tick;
    check("sim_v1", 32'(evt_valid), 1);
    check("sim_i1", 32'(evt_idx), 5);
    tick;
    check("sim_v2", 32'(evt_valid), 1);
    check("sim_i2", 32'(evt_idx), 12);
    tick;
    check("sim_end_valid", 32'(evt_valid), 0);
    check("sim_end_busy", 32'(busy), 0);

    // Lanes 2 and 17 with rr_ptr=13
    edge_pulse = 18'h20004;
    tick;
    edge_pulse = '0;
    tick;
    check("wrap_v1", 32'(evt_valid), 1);
`ifdef SW_ARB_FIXED_PRIO_EN
    check("wrap_i1", 32'(evt_idx), 2);
`else
    check("wrap_i1", 32'(evt_idx), 17);
`endif
    tick;
    check("wrap_v2", 32'(evt_valid), 1);
`ifdef SW_ARB_FIXED_PRIO_EN
    check("wrap_i2", 32'(evt_idx), 17);
`else
    check("wrap_i2", 32'(evt_idx), 2);
`endif
    tick;
    check("wrap_end", 32'(evt_valid), 0);

    // Single event on lane 5
    edge_pulse = 18'h00020;
    tick;
    edge_pulse = '0;
    tick;
    check("single_v", 32'(evt_valid), 1);
    check("single_i", 32'(evt_idx), 5);
    tick;
    check("single_v_off", 32'(evt_valid), 0);
    check("single_busy", 32'(busy), 0);

    // Backpressure: lane 5 held while lane 3 pulses
    evt_ready = 1'b0;
    edge_pulse = 18'h00020;
    tick;
    edge_pulse = 18'h00008;
    tick;
    edge_pulse = '0;
    check("bp_v0", 32'(evt_valid), 1);
    check("bp_i0", 32'(evt_idx), 5);
    for (int c = 0; c < 3; c++) begin
      tick;
      check("bp_hold_v", 32'(evt_valid), 1);
      check("bp_hold_i", 32'(evt_idx), 5);
    end
    check("bp_pending", 32'(pending), 32'h00008);
    evt_ready = 1'b1;
    tick;
    check("bp_next_v", 32'(evt_valid), 1);
    check("bp_next_i", 32'(evt_idx), 3);
    tick;
    check("bp_end", 32'(evt_valid), 0);

    // Overflow on lane 7 while lane 1 is stalled
    evt_ready = 1'b0;
    edge_pulse = 18'h00002;
    tick;
    edge_pulse = 18'h00080;
    tick;
    edge_pulse = 18'h00080;
    tick;
    edge_pulse = '0;
    check("ovf_flag", 32'(overflow), 32'h00080);
    check("ovf_offer_i", 32'(evt_idx), 1);
    check("ovf_pending", 32'(pending), 32'h00080);
    evt_ready = 1'b1;
    tick;
    check("ovf_v7", 32'(evt_valid), 1);
    check("ovf_i7", 32'(evt_idx), 7);
    tick;
    check("ovf_once", 32'(evt_valid), 0);
    check("ovf_sticky", 32'(overflow), 32'h00080);
    ovf_clr = 1'b1;
    tick;
    ovf_clr = 1'b0;
    check("ovf_clr", 32'(overflow), 0);

    // Asynchronous reset in the middle of an offer
    evt_ready = 1'b0;
    edge_pulse = 18'h00200;
    tick;
    edge_pulse = 18'h00400;
    tick;
    edge_pulse = 18'h00400;
    tick;
    edge_pulse = '0;
    check("mid_v", 32'(evt_valid), 1);
    check("mid_i", 32'(evt_idx), 9);
    check("mid_ovf", 32'(overflow), 32'h00400);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(evt_valid), 0);
    check("arst_idx", 32'(evt_idx), 0);
    check("arst_pending", 32'(pending), 0);
    check("arst_overflow", 32'(overflow), 0);
    check("arst_busy", 32'(busy), 0);
    tick;
    rst = 1'b0;
    evt_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick;
      check("post_rst_valid", 32'(evt_valid), 0);
      check("post_rst_busy", 32'(busy), 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/switch_event_arbiter.md
Name: switch_event_arbiter

Overview:
- Collects single-cycle edge pulses from the `edge_detect` block (NUM_BITS switch lanes) into a pending set.
- Serves the pending events one at a time to a downstream consumer over a valid/ready handshake.
- Arbitration is round-robin, so no switch can starve the others.
- Sits between `edge_detect` and the UI/command logic that acts on switch presses.

Parameters:
- NUM_BITS, 18, number of switch lanes; must be ≥2.
- IDX_W, $clog2(NUM_BITS), width of event index; derived, do not override.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- edge_pulse  input  NUM_BITS  one-cycle pulses from `edge_detect`; several bits may be high at once.
- evt_valid  output  1  an event is being offered.
- evt_idx  output  IDX_W  lane number of the offered event.
- evt_ready  input  1  consumer accepts when high together with evt_valid.
- pending  output  NUM_BITS  registered pending set (debug/status).
- overflow  output  NUM_BITS  sticky per-lane lost-event flags.
- ovf_clr  input  1  synchronous clear of all overflow bits.
- busy  output  1  high when evt_valid high or pending ≠ 0.

Behaviour:
- Reset (async, immediate): pending=0, overflow=0, evt_valid=0, evt_idx=0, rr_ptr=0, state=IDLE.
- Pending update each edge: pending_next = (pending & ~grant_mask) | edge_pulse.
  - A set on the same lane as a grant wins; the lane stays pending.
- Overflow:
  - overflow[i] sets when edge_pulse[i] & pending[i] & ~grant_mask[i] (event merged, i.e. lost).
  - ovf_clr clears all bits; a set in the same cycle wins.
- States IDLE, OFFER.
- IDLE: if pending ≠ 0, pick lane g = first set bit searching upward from rr_ptr, wrapping NUM_BITS-1→0.
  - Load evt_idx=g, set evt_valid=1, grant_mask=onehot(g), go to OFFER.
  - Otherwise stay in IDLE with evt_valid=0.
- OFFER:
  - evt_valid and evt_idx held stable while evt_ready=0; no re-arbitration.
  - On evt_valid & evt_ready: rr_ptr = (evt_idx==NUM_BITS-1) ? 0 : evt_idx+1.
    - If pending ≠ 0, grant the next lane from the new pointer in the same edge (back-to-back, evt_valid stays 1).
    - Else go to IDLE with evt_valid=0.
- Latency:
  - Pulse sampled at edge k → pending at edge k → evt_valid high after edge k+1 (from IDLE).
  - Throughput is 1 event/cycle when evt_ready is held high.
- A granted lane is cleared from pending at grant time; a new pulse on the offered lane re-pends it without setting overflow.
- Wrap-around: rr_ptr never takes values ≥ NUM_BITS.
- Reset asserted mid-offer: the event is dropped and outputs are zeroed immediately.
- busy = evt_valid | (|pending), combinational from registers.

Optional Feature:
- SW_ARB_FIXED_PRIO_EN
  - Defined: fixed priority, lowest set index always wins; rr_ptr removed (tied 0).
  - Undefined (default): round-robin as above.
  - Handshake, overflow and latency are identical in both modes.

Decomposition:
- Package sw_evt_pkg:
  - arb_state_t enum {IDLE, OFFER}.
  - Function next_idx(idx, n) for wrap increment.
  - Localparam defaults (NUM_BITS_DEF=18).
- One combinational sub-module rr_select (inputs: request vector, start pointer; outputs: found, index).
  - Fixed-priority mode reuses it with pointer 0.

Test Plan:
- Reset: rst=1 mid-run while evt_valid=1 → all outputs 0 within the same time step; after release with edge_pulse=0, evt_valid stays 0.
- Single event: edge_pulse=18'h00020 for one cycle, evt_ready=1 → evt_valid=1, evt_idx=5 after the next edge, one cycle wide, then busy=0.
- Simultaneous: edge_pulse=bits 5 and 12 in one cycle, evt_ready=1 → evt_idx 5 then 12 on consecutive cycles; rr_ptr=13 afterwards.
- Fairness/wrap: rr_ptr=13, pending bits 2 and 17 → order 17 then 2; with SW_ARB_FIXED_PRIO_EN defined → order 2 then 17.
- Backpressure: offer idx 5 with evt_ready=0 for 4 cycles while pulsing lane 3 → idx holds 5; after accept, idx 3 is offered.
- Overflow: pulse lane 7 twice while lane 7 is pending and not granted → overflow[7]=1 and only one lane-7 event is delivered; ovf_clr → overflow=0.
